// File: rtl/cfg_capture_pkg.sv
// rtl/cfg_capture_pkg.sv - shared state encoding and default constants for cfg_capture_sync
package cfg_capture_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    HOLD    = 2'd1,
    RUN     = 2'd2
  } cfg_state_e;

  localparam int SYNC_DEPTH_DEF = 2;
  localparam int STABLE_CYC_DEF = 4;

endpackage

// File: rtl/rst_sync_chain.sv
// rtl/rst_sync_chain.sv - shift chain that releases rst_n_sync SYNC_DEPTH edges after rst_n goes high
module rst_sync_chain
  import cfg_capture_pkg::*;
#(
  parameter int SYNC_DEPTH = SYNC_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_DEPTH-1:0] chain_q;
  logic [SYNC_DEPTH-1:0] chain_d;

  // shift a one in per high edge; any low edge clears the whole chain
  always_comb begin
    chain_d = chain_q;
    if (!rst_n) begin
      chain_d = '0;
    end else begin
      chain_d = {chain_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  // chain register
  always_ff @(posedge clk) begin
    chain_q <= chain_d;
  end

  assign rst_n_sync = chain_q[SYNC_DEPTH-1];

endmodule

// File: rtl/cfg_capture_sync.sv
// rtl/cfg_capture_sync.sv - captures stable configuration during reset and releases it synchronised; optional readback under CFG_CAPTURE_READBACK_EN
module cfg_capture_sync
  import cfg_capture_pkg::*;
#(
  parameter int               NCH         = 4,
  parameter int               W           = 8,
  parameter int               SYNC_DEPTH  = SYNC_DEPTH_DEF,
  parameter int               STABLE_CYC  = STABLE_CYC_DEF,
  parameter logic [NCH*W-1:0] CFG_DEFAULT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [NCH*W-1:0]   ch_in,
  output logic               rst_n_sync,
  output logic [NCH*W-1:0]   cfg_out,
  output logic               cfg_valid,
  output logic               cfg_err
`ifdef CFG_CAPTURE_READBACK_EN
  ,
  input  logic [$clog2(NCH)-1:0] rd_sel,
  output logic [W-1:0]           rd_data
`endif
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int HW = $clog2(SYNC_DEPTH);

  cfg_state_e         state_q, state_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCH*W-1:0]   sample_q, sample_d;
  logic [NCH*W-1:0]   cfg_out_q, cfg_out_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               capture_edge;
  logic               release_edge;
  logic               stable_ok;

  // all flops; reset is folded into the next-value logic so sample_q can stay unreset
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    hold_cnt_q  <= hold_cnt_d;
    cnt_q       <= cnt_d;
    sample_q    <= sample_d;
    cfg_out_q   <= cfg_out_d;
    cfg_err_q   <= cfg_err_d;
    cfg_valid_q <= cfg_valid_d;
  end

  // next state: capture while reset is low, then hold for the synchroniser latency, then run
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (!rst_n) begin
      state_d    = CAPTURE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        CAPTURE: begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
        HOLD: begin
          if (hold_cnt_q == HW'(SYNC_DEPTH - 2)) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = CAPTURE;
        end
      endcase
    end
  end

  assign capture_edge = rst_n && (state_q == CAPTURE);
  assign release_edge = (state_q == HOLD) && (state_d == RUN);
  assign stable_ok    = (cnt_q >= CW'(STABLE_CYC - 1));

  // stability tracker: counts consecutive equal samples, saturating at STABLE_CYC
  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    if (state_q == CAPTURE) begin
      if (!ena) begin
        cnt_d = '0;
      end else if (ch_in == sample_q) begin
        if (cnt_q != CW'(STABLE_CYC)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        sample_d = ch_in;
        cnt_d    = '0;
      end
    end else if (!rst_n) begin
      cnt_d = '0;
    end
  end

  // outputs: freeze the configuration on leaving CAPTURE, raise valid together with the released reset
  always_comb begin
    cfg_out_d   = cfg_out_q;
    cfg_err_d   = cfg_err_q;
    cfg_valid_d = cfg_valid_q;
    if (!rst_n) begin
      cfg_out_d   = CFG_DEFAULT;
      cfg_err_d   = 1'b0;
      cfg_valid_d = 1'b0;
    end else if (capture_edge) begin
      if (stable_ok) begin
        cfg_out_d = sample_q;
        cfg_err_d = 1'b0;
      end else begin
        cfg_out_d = CFG_DEFAULT;
        cfg_err_d = 1'b1;
      end
    end else if (release_edge) begin
      cfg_valid_d = !cfg_err_q;
    end
  end

  rst_sync_chain #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_rst_sync_chain (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync)
  );

  assign cfg_out   = cfg_out_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_valid = cfg_valid_q;

`ifdef CFG_CAPTURE_READBACK_EN
  localparam int SW = $clog2(NCH);

  logic [W-1:0] ch_tab [2**SW];
  logic [W-1:0] rd_data_q, rd_data_d;

  // select table padded with zeros so unused select codes read back 0
  for (genvar k = 0; k < 2**SW; k++) begin : g_tab
    if (k < NCH) begin : g_ch
      assign ch_tab[k] = cfg_out_q[k*W +: W];
    end else begin : g_pad
      assign ch_tab[k] = '0;
    end
  end

  // readback mux, held at zero while reset is low
  always_comb begin
    rd_data_d = '0;
    if (rst_n) begin
      rd_data_d = ch_tab[rd_sel];
    end
  end

  // readback register
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_cfg_capture_sync.sv
// tb/tb_cfg_capture_sync.sv - directed self-checking bench for cfg_capture_sync
module tb_cfg_capture_sync;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [31:0] ch_in;
  logic        rst_n_sync;
  logic [31:0] cfg_out;
  logic        cfg_valid;
  logic        cfg_err;
`ifdef CFG_CAPTURE_READBACK_EN
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
`endif

  int tests_run;
  int tests_failed;

  cfg_capture_sync #(
    .NCH (4),
    .W   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ch_in      (ch_in),
    .rst_n_sync (rst_n_sync),
    .cfg_out    (cfg_out),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err)
`ifdef CFG_CAPTURE_READBACK_EN
    ,
    .rd_sel     (rd_sel),
    .rd_data    (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    ch_in = 32'h0;
    repeat (3) tick();
    tests_run++;
    if (rst_n_sync !== 1'b0) begin tests_failed++; $display("FAIL reset_sync: got %b want 0", rst_n_sync); end
    tests_run++;
    if (cfg_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", cfg_valid); end
    tests_run++;
    if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    tests_run++;
    if (cfg_out !== 32'h0) begin tests_failed++; $display("FAIL reset_cfg_out: got %h want 00000000", cfg_out); end
`ifdef CFG_CAPTURE_READBACK_EN
    rd_sel = 2'd2;
    tick();
    tests_run++;
    if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
`endif
  endtask

  task automatic test_capture_ok();
    rst_n = 1'b0;
    ena   = 1'b1;
    ch_in = 32'hA5C3_0F11;
    repeat (10) tick();
    tests_run++;
    if (cfg_out !== 32'h0) begin tests_failed++; $display("FAIL ok_cfg_in_reset: got %h want 00000000", cfg_out); end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cfg_out !== 32'hA5C3_0F11) begin tests_failed++; $display("FAIL ok_cfg_out: got %h want a5c30f11", cfg_out); end
    tests_run++;
    if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL ok_err: got %b want 0", cfg_err); end
    tests_run++;
    if (rst_n_sync !== 1'b0 || cfg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ok_edge1_early: got sync=%b valid=%b want 0 0", rst_n_sync, cfg_valid);
    end
    tick();
    tests_run++;
    if (rst_n_sync !== 1'b1 || cfg_valid !== 1'b1) begin
      tests_failed++; $display("FAIL ok_edge2_release: got sync=%b valid=%b want 1 1", rst_n_sync, cfg_valid);
    end
  endtask

`ifdef CFG_CAPTURE_READBACK_EN
  task automatic test_readback();
    rd_sel = 2'd2;
    tick();
    tests_run++;
    if (rd_data !== 8'hC3) begin tests_failed++; $display("FAIL rd_sel2: got %h want c3", rd_data); end
    rd_sel = 2'd0;
    tick();
    tests_run++;
    if (rd_data !== 8'h11) begin tests_failed++; $display("FAIL rd_sel0: got %h want 11", rd_data); end
    rd_sel = 2'd3;
    tick();
    tests_run++;
    if (rd_data !== 8'hA5) begin tests_failed++; $display("FAIL rd_sel3: got %h want a5", rd_data); end
  endtask
`endif

  task automatic test_run_freeze();
    for (int i = 0; i < 4; i++) begin
      ch_in = 32'h1234_5678 + 32'(i * 32'h0101_0101);
      tick();
      tests_run++;
      if (cfg_out !== 32'hA5C3_0F11 || cfg_valid !== 1'b1) begin
        tests_failed++; $display("FAIL run_freeze[%0d]: got cfg=%h valid=%b want a5c30f11 1", i, cfg_out, cfg_valid);
      end
    end
  endtask

  task automatic test_unstable();
    rst_n = 1'b0;
    ena   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ch_in = (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      tick();
    end
    ch_in = 32'h3333_3333;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_out !== 32'h0) begin
      tests_failed++; $display("FAIL unstable_err: got err=%b cfg=%h want 1 00000000", cfg_err, cfg_out);
    end
    tests_run++;
    if (rst_n_sync !== 1'b0) begin tests_failed++; $display("FAIL unstable_sync_early: got %b want 0", rst_n_sync); end
    tick();
    tests_run++;
    if (rst_n_sync !== 1'b1 || cfg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL unstable_release: got sync=%b valid=%b want 1 0", rst_n_sync, cfg_valid);
    end
  endtask

  task automatic test_stable_boundary(input int n_edges, input logic exp_ok);
    rst_n = 1'b0;
    ena   = 1'b1;
    ch_in = 32'h0000_00AA;
    tick();
    ch_in = 32'h0000_00BB;
    tick();
    ch_in = 32'h7E57_0B0B;
    repeat (n_edges) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cfg_err !== !exp_ok) begin
      tests_failed++; $display("FAIL boundary_err[%0d]: got %b want %b", n_edges, cfg_err, !exp_ok);
    end
    tests_run++;
    if (cfg_out !== (exp_ok ? 32'h7E57_0B0B : 32'h0)) begin
      tests_failed++; $display("FAIL boundary_cfg[%0d]: got %h want %h", n_edges, cfg_out, (exp_ok ? 32'h7E57_0B0B : 32'h0));
    end
    tick();
    tests_run++;
    if (cfg_valid !== exp_ok || rst_n_sync !== 1'b1) begin
      tests_failed++; $display("FAIL boundary_release[%0d]: got valid=%b sync=%b want %b 1", n_edges, cfg_valid, rst_n_sync, exp_ok);
    end
  endtask

  task automatic test_ena_low();
    rst_n = 1'b0;
    ena   = 1'b0;
    ch_in = 32'h5A5A_5A5A;
    repeat (10) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_out !== 32'h0) begin
      tests_failed++; $display("FAIL ena_low_err: got err=%b cfg=%h want 1 00000000", cfg_err, cfg_out);
    end
    tick();
    tests_run++;
    if (rst_n_sync !== 1'b1 || cfg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ena_low_release: got sync=%b valid=%b want 1 0", rst_n_sync, cfg_valid);
    end
    ena = 1'b1;
  endtask

  task automatic test_hold_glitch();
    rst_n = 1'b0;
    ena   = 1'b1;
    ch_in = 32'hCAFE_0001;
    repeat (10) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cfg_out !== 32'hCAFE_0001 || cfg_err !== 1'b0 || rst_n_sync !== 1'b0) begin
      tests_failed++; $display("FAIL glitch_hold: got cfg=%h err=%b sync=%b want cafe0001 0 0", cfg_out, cfg_err, rst_n_sync);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (rst_n_sync !== 1'b0 || cfg_out !== 32'h0 || cfg_err !== 1'b0 || cfg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL glitch_low: got sync=%b cfg=%h err=%b valid=%b want 0 00000000 0 0", rst_n_sync, cfg_out, cfg_err, cfg_valid);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (rst_n_sync !== 1'b0 || cfg_err !== 1'b1) begin
      tests_failed++; $display("FAIL glitch_recapture: got sync=%b err=%b want 0 1", rst_n_sync, cfg_err);
    end
    tick();
    tests_run++;
    if (rst_n_sync !== 1'b1 || cfg_valid !== 1'b0 || cfg_out !== 32'h0) begin
      tests_failed++; $display("FAIL glitch_release: got sync=%b valid=%b cfg=%h want 1 0 00000000", rst_n_sync, cfg_valid, cfg_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    ena          = 1'b1;
    ch_in        = 32'h0;
`ifdef CFG_CAPTURE_READBACK_EN
    rd_sel       = 2'd0;
`endif
    test_reset();
    test_capture_ok();
`ifdef CFG_CAPTURE_READBACK_EN
    test_readback();
`endif
    test_run_freeze();
    test_unstable();
    test_stable_boundary(4, 1'b1);
    test_stable_boundary(3, 1'b0);
    test_ena_low();
    test_hold_glitch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
